rtc_sequencer: RTL and testbench
================================

RTC_SEQUENCER -- requirements
Module: rtc_sequencer

Interface
REQ-001 SHALL have parameter NREG, default 6, number of RTC time registers per burst.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waiting for done before abort.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port rd_req, input, 1, one-cycle pulse requesting a full time read burst.
REQ-006 SHALL have port wr_req, input, 1, one-cycle pulse requesting a full time write burst.
REQ-007 SHALL have port wr_time, input, 8*NREG, BCD bytes to write; byte i goes to register i.
REQ-008 SHALL have port rd_time, output, 8*NREG, last completed read burst; byte i from register i.
REQ-009 SHALL have port rd_valid, output, 1, one-cycle pulse when rd_time updated.
REQ-010 SHALL have port busy, output, 1, high from request acceptance to burst end.
REQ-011 SHALL have port err, output, 1, sticky timeout flag.
REQ-012 SHALL have port access, output, 1, one-cycle start pulse to the bus transfer stage.
REQ-013 SHALL have port read, output, 1, transfer direction (1 read, 0 write), held stable while busy.
REQ-014 SHALL have port addr, output, 8, RTC register address of current transfer.
REQ-015 SHALL have port wdata, output, 8, write byte of current transfer.
REQ-016 SHALL have port done, input, 1, one-cycle pulse from transfer stage at cycle end.
REQ-017 SHALL have port rdata, input, 8, read byte, valid in the cycle done is high.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, NEXT.
REQ-019 IDLE: on wr_req or rd_req SHALL latch direction, snapshot wr_time, clear index, go ISSUE next cycle.
REQ-020 wr_req and rd_req in the same cycle SHALL start the write first and keep the read pending; pending read SHALL start on the cycle after write burst end.
REQ-021 Requests while busy SHALL set pending (one deep per kind); duplicates SHALL be dropped.
REQ-022 ISSUE SHALL drive access=1 for exactly one cycle with addr=ADDR_BASE+index and wdata=snapshot byte[index], then go WAIT.
REQ-023 WAIT: on done SHALL capture rdata into shadow byte[index] (read only) and go NEXT.
REQ-024 NEXT: index<NREG-1 SHALL increment index and go ISSUE; else go IDLE.
REQ-025 Read burst completion SHALL copy shadow to rd_time and pulse rd_valid in the same cycle the FSM returns to IDLE; rd_time SHALL never show a partial burst.
REQ-026 Minimum access-to-access spacing SHALL be 3 cycles (ISSUE, WAIT with immediate done, NEXT).
REQ-027 done outside WAIT SHALL be ignored.
REQ-028 addr and wdata SHALL stay stable from ISSUE until leaving WAIT.

Reset
REQ-029 reset SHALL force IDLE, index=0, pending clear, access=0, read=1, addr=0, wdata=0, rd_time=0, rd_valid=0, busy=0, err=0, effective next edge, including mid-burst.

Configuration
REQ-030 With RTC_SEQ_TIMEOUT_EN defined, a WAIT counter SHALL abort the burst after TIMEOUT cycles without done: set err, return IDLE, discard shadow, no rd_valid; err clears only on reset.
REQ-031 Without RTC_SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely and err SHALL be tied 0.

Structure
REQ-032 A shared package SHALL hold the state encoding, ADDR_BASE=8'h21 (seconds; minutes..year follow consecutively), and default NREG/TIMEOUT.
REQ-033 The timeout counter SHALL be a sub-module rtc_seq_timer (load, tick, expired).

Verification
REQ-034 rd_req after reset, done 4 cycles after each access, rdata=8'h10..8'h15 -> six accesses, addr 21..26, rd_time=48'h151413121110, one rd_valid.
REQ-035 wr_req with wr_time=48'h241231235959 -> read=0, six accesses, wdata 59,59,23,31,12,24 on addr 21..26, no rd_valid.
REQ-036 wr_req and rd_req same cycle -> full write burst then read burst, busy continuously high, no access gap >3 cycles between bursts.
REQ-037 reset asserted during third WAIT -> next cycle all outputs at reset values, later done ignored.
REQ-038 RTC_SEQ_TIMEOUT_EN, TIMEOUT=255, done withheld -> err=1 at cycle 255 of WAIT, busy=0, no rd_valid; without macro busy stays high.

Source files
------------

// File: rtl/rtc_sequencer_pkg.sv
// rtc_sequencer_pkg: state encoding, RTC register base address and default burst parameters
package rtc_sequencer_pkg;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_NEXT  = 2'd3;
   localparam logic [7:0] ADDR_BASE = 8'h21;
   localparam int NREG_DEF = 6;
   localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/rtc_sequencer_if.sv
// rtc_sequencer_if: single-register transfer handshake between sequencer (master) and bus stage (slave)
interface rtc_sequencer_if;
   logic       access;
   logic       read;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       done;
   logic [7:0] rdata;
   modport master (output access, read, addr, wdata, input done, rdata);
   modport slave (input access, read, addr, wdata, output done, rdata);
endinterface

// File: rtl/rtc_seq_timer.sv
// rtc_seq_timer: counts ticks since load, expired flags the TIMEOUT-th consecutive tick
module rtc_seq_timer
   import rtc_sequencer_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic tick,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk)
      if (reset || load) cnt <= '0;
      else if (tick) cnt <= cnt + 1'b1;
   assign expired = tick && cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/rtc_sequencer.sv
// rtc_sequencer: NREG-register RTC time read/write burst sequencer
// optional WAIT abort timer enabled by defining RTC_SEQ_TIMEOUT_EN
module rtc_sequencer
   import rtc_sequencer_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic [8*NREG-1:0] wr_time,
   output logic [8*NREG-1:0] rd_time,
   output logic              rd_valid,
   output logic              busy,
   output logic              err,
   rtc_sequencer_if.master   bus
);
   localparam int IW = NREG > 1 ? $clog2(NREG) : 1;
   logic [1:0] st;
   logic [IW-1:0] idx, nidx;
   logic pend_rd, pend_wr, start_wr, start, last, expired;
   logic [8*NREG-1:0] snap, shadow;
   assign start_wr = wr_req | pend_wr;
   assign start = start_wr | rd_req | pend_rd;
   assign last = idx == IW'(NREG - 1);
   assign nidx = idx + 1'b1;
`ifdef RTC_SEQ_TIMEOUT_EN
   rtc_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk(clk),
      .reset(reset),
      .load(st == S_ISSUE),
      .tick(st == S_WAIT && !bus.done),
      .expired(expired)
   );
`else
   assign expired = TIMEOUT < 0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         st <= S_IDLE;
         idx <= '0;
         pend_rd <= 1'b0;
         pend_wr <= 1'b0;
         bus.access <= 1'b0;
         bus.read <= 1'b1;
         bus.addr <= 8'h00;
         bus.wdata <= 8'h00;
         rd_time <= '0;
         rd_valid <= 1'b0;
         busy <= 1'b0;
         err <= 1'b0;
         snap <= '0;
         shadow <= '0;
      end else begin
         rd_valid <= 1'b0;
         bus.access <= 1'b0;
         if (st != S_IDLE) begin
            pend_wr <= pend_wr | wr_req;
            pend_rd <= pend_rd | rd_req;
         end
         case (st)
            S_IDLE: if (start) begin
               st <= S_ISSUE;
               idx <= '0;
               busy <= 1'b1;
               bus.access <= 1'b1;
               bus.read <= !start_wr;
               bus.addr <= ADDR_BASE;
               bus.wdata <= wr_time[7:0];
               snap <= wr_time;
               pend_wr <= 1'b0;
               pend_rd <= start_wr & (pend_rd | rd_req);
            end
            S_ISSUE: st <= S_WAIT;
            S_WAIT: if (bus.done) begin
               if (bus.read) shadow[{idx, 3'b000} +: 8] <= bus.rdata;
               st <= S_NEXT;
            end else if (expired) begin
               err <= 1'b1;
               st <= S_IDLE;
               busy <= pend_rd | pend_wr | rd_req | wr_req;
            end
            S_NEXT: if (!last) begin
               idx <= nidx;
               st <= S_ISSUE;
               bus.access <= 1'b1;
               bus.addr <= ADDR_BASE + 8'(nidx);
               bus.wdata <= snap[{nidx, 3'b000} +: 8];
            end else begin
               st <= S_IDLE;
               busy <= pend_rd | pend_wr | rd_req | wr_req;
               if (bus.read) begin
                  rd_time <= shadow;
                  rd_valid <= 1'b1;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rtc_sequencer.sv
// tb_rtc_sequencer: directed bursts against a delayed-done bus responder model
module tb_rtc_sequencer;
   logic clk, reset, rd_req, wr_req, rd_valid, busy, err;
   logic [47:0] wr_time, rd_time;
   rtc_sequencer_if bus();
   rtc_sequencer #(.NREG(6), .TIMEOUT(255)) dut (
      .clk(clk),
      .reset(reset),
      .rd_req(rd_req),
      .wr_req(wr_req),
      .wr_time(wr_time),
      .rd_time(rd_time),
      .rd_valid(rd_valid),
      .busy(busy),
      .err(err),
      .bus(bus)
   );
   int n_chk, n_err, cyc, acc_n, rv_n, dn_n, cd, dly, cur_k;
   logic resp_en;
   logic [7:0] rbase;
   logic [7:0] log_addr [32];
   logic [7:0] log_wdata [32];
   logic log_read [32];
   int log_cyc [32];
   int log_dcyc [32];
   logic [47:0] rv_time;
   logic [7:0] exp_w [6] = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h24};
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bus.done = 1'b0;
      bus.rdata = 8'h00;
      forever begin
         @(negedge clk);
         cyc++;
         bus.done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               bus.done = 1'b1;
               bus.rdata = rbase + 8'(cur_k);
               if (dn_n < 32) log_dcyc[dn_n] = cyc;
               dn_n++;
            end
         end
         if (bus.access && !reset) begin
            if (acc_n < 32) begin
               log_addr[acc_n] = bus.addr;
               log_wdata[acc_n] = bus.wdata;
               log_read[acc_n] = bus.read;
               log_cyc[acc_n] = cyc;
            end
            cur_k = acc_n % 6;
            acc_n++;
            if (resp_en) cd = dly;
         end
         if (rd_valid) begin
            rv_n++;
            rv_time = rd_time;
         end
      end
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic pulse(input logic w, input logic r);
      @(posedge clk);
      #1 wr_req = w;
      rd_req = r;
      @(posedge clk);
      #1 wr_req = 1'b0;
      rd_req = 1'b0;
   endtask
   task automatic wait_idle(input int lim);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy && k < lim);
      check("idle_wait", busy, 0);
      repeat (2) @(negedge clk);
   endtask
   task automatic clear_logs();
      @(posedge clk);
      acc_n = 0;
      rv_n = 0;
      dn_n = 0;
   endtask
   task automatic chk_reset();
      check("rst_busy", busy, 0);
      check("rst_access", bus.access, 0);
      check("rst_read", bus.read, 1);
      check("rst_addr", bus.addr, 8'h00);
      check("rst_wdata", bus.wdata, 8'h00);
      check("rst_rd_time", rd_time, 48'h0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_err", err, 0);
   endtask
   initial begin
      int seen, n;
      reset = 1'b1;
      rd_req = 1'b0;
      wr_req = 1'b0;
      wr_time = '0;
      resp_en = 1'b1;
      dly = 4;
      rbase = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_reset();
      clear_logs();
      rbase = 8'h10;
      pulse(1'b0, 1'b1);
      wait_idle(200);
      check("rd_count", acc_n, 6);
      for (int i = 0; i < 6; i++) begin
         check("rd_addr", log_addr[i], 8'h21 + i);
         check("rd_dir", log_read[i], 1);
      end
      check("rd_time", rd_time, 48'h151413121110);
      check("rd_valid_n", rv_n, 1);
      check("rd_valid_data", rv_time, 48'h151413121110);
      check("rd_spacing", log_cyc[1] - log_cyc[0], 6);
      clear_logs();
      wr_time = 48'h241231235959;
      pulse(1'b1, 1'b0);
      wr_time = '1;
      wait_idle(200);
      check("wr_count", acc_n, 6);
      for (int i = 0; i < 6; i++) begin
         check("wr_wdata", log_wdata[i], exp_w[i]);
         check("wr_addr", log_addr[i], 8'h21 + i);
         check("wr_dir", log_read[i], 0);
      end
      check("wr_no_valid", rv_n, 0);
      check("wr_rd_time_kept", rd_time, 48'h151413121110);
      clear_logs();
      dly = 1;
      rbase = 8'h30;
      wr_time = 48'h0a0b0c0d0e0f;
      pulse(1'b1, 1'b1);
      wr_time = '0;
      wait_idle(400);
      check("both_count", acc_n, 12);
      check("both_first_wr", log_read[0], 0);
      check("both_last_wr", log_read[5], 0);
      check("both_first_rd", log_read[6], 1);
      check("both_last_rd", log_read[11], 1);
      check("both_wdata0", log_wdata[0], 8'h0f);
      check("both_wdata5", log_wdata[5], 8'h0a);
      check("both_rd_addr0", log_addr[6], 8'h21);
      check("min_spacing", log_cyc[1] - log_cyc[0], 3);
      check("burst_gap", (log_cyc[6] - log_dcyc[5]) <= 3, 1);
      check("both_rd_time", rd_time, 48'h353433323130);
      check("both_valid_n", rv_n, 1);
      clear_logs();
      rbase = 8'h40;
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      wait_idle(400);
      check("dup_count", acc_n, 12);
      check("dup_valid_n", rv_n, 2);
      check("dup_rd_time", rd_time, 48'h454443424140);
      clear_logs();
      dly = 4;
      rbase = 8'h50;
      pulse(1'b0, 1'b1);
      seen = 0;
      for (int i = 0; i < 100 && seen < 3; i++) begin
         @(negedge clk);
         if (bus.access) seen++;
      end
      check("mid_reach", seen, 3);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_reset();
      n = acc_n;
      repeat (10) @(negedge clk);
      check("mid_no_access", acc_n, n);
      check("mid_busy", busy, 0);
      check("mid_no_valid", rv_n, 0);
      check("mid_rd_time", rd_time, 48'h0);
      clear_logs();
      resp_en = 1'b0;
      pulse(1'b0, 1'b1);
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk);
         if (bus.access) seen = 1;
      end
      check("to_access", seen, 1);
`ifdef RTC_SEQ_TIMEOUT_EN
      repeat (255) @(negedge clk);
      check("to_err_before", err, 0);
      check("to_busy_before", busy, 1);
      @(negedge clk);
      check("to_err", err, 1);
      check("to_busy", busy, 0);
      repeat (5) @(negedge clk);
      check("to_err_sticky", err, 1);
      check("to_no_valid", rv_n, 0);
      check("to_rd_time", rd_time, 48'h0);
`else
      repeat (300) @(negedge clk);
      check("hang_busy", busy, 1);
      check("hang_err", err, 0);
      check("hang_no_valid", rv_n, 0);
`endif
      resp_en = 1'b1;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
